uart_rx: RTL and testbench

- UART receiver: the far-end stage that consumes the serial line driven by the team's UART transmitter.
- Oversamples RX_IN at PRESCALE ticks per bit and detects the start bit.
- Majority-samples each bit, shifts in data LSB-first, and checks optional parity and the stop bit.
- Presents a parallel word with a one-cycle Data_Valid pulse, matching the handshake the transmitter accepts.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sampler.sv | 69 ++++++
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types, parity constants and parity helper (RX/TX).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Words narrower than 32 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [31:0] i_data, input logic i_typ);
    logic w_x;
    w_x = ^i_data;
    return (i_typ == PAR_EVEN) ? w_x : ((i_typ == PAR_ODD) ? ~w_x : w_x);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// Module   : uart_rx_sampler
// Brief    : Per-bit edge/bit counters and 3-sample majority vote for uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = 8,
  parameter int BIT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_active,
  input  logic             i_rx,
  output logic             o_sampled_bit,
  output logic             o_sample_strobe,
  output logic             o_bit_end,
  output logic [BIT_W-1:0] o_bit_cnt
);

  localparam int c_EDGE_W = $clog2(PRESCALE);
  localparam int c_MID    = PRESCALE / 2;

  logic [c_EDGE_W-1:0] r_edge_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic                r_s0;
  logic                r_s1;
  logic                w_last_edge;

  assign w_last_edge = (r_edge_cnt == c_EDGE_W'(PRESCALE - 1));

  // The detection cycle is edge 0, so the counter resumes at edge 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
    end else if (i_start) begin
      r_edge_cnt <= c_EDGE_W'(1);
      r_bit_cnt  <= '0;
    end else if (i_active) begin
      if (w_last_edge) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
      end else begin
        r_edge_cnt <= r_edge_cnt + c_EDGE_W'(1);
      end
      if (r_edge_cnt == c_EDGE_W'(c_MID - 1)) r_s0 <= i_rx;
      if (r_edge_cnt == c_EDGE_W'(c_MID))     r_s1 <= i_rx;
    end else begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end
  end

  // Third sample is the live line at edge M+1, where the vote is decided.
  assign o_sampled_bit   = (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
  assign o_sample_strobe = i_active && (r_edge_cnt == c_EDGE_W'(c_MID + 1));
  assign o_bit_end       = i_active && w_last_edge;
  assign o_bit_cnt       = r_bit_cnt;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver with optional parity and stop check.
//            Define RX_SYNC_EN to insert a 2-flop synchronizer on RX_IN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int c_BIT_W = $clog2(DATA_WIDTH + 3);

  uart_state_e           r_state;
  uart_state_e           w_next;
  logic                  w_rx;
  logic                  w_start;
  logic                  w_done;
  logic                  w_active;
  logic                  w_bit;
  logic                  w_strobe;
  logic                  w_bit_end;
  logic [c_BIT_W-1:0]    w_bit_cnt;
  logic                  r_prev_rx;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_bad;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

`ifdef RX_SYNC_EN
  logic [1:0] r_rx_sync;
  always_ff @(posedge clk) begin
    if (rst) r_rx_sync <= 2'b11;
    else     r_rx_sync <= {r_rx_sync[0], RX_IN};
  end
  assign w_rx = r_rx_sync[1];
`else
  assign w_rx = RX_IN;
`endif

  assign w_active = (r_state != IDLE);

  uart_rx_sampler #(
    .PRESCALE (PRESCALE),
    .BIT_W    (c_BIT_W)
  ) u_sampler (
    .clk             (clk),
    .rst             (rst),
    .i_start         (w_start),
    .i_active        (w_active),
    .i_rx            (w_rx),
    .o_sampled_bit   (w_bit),
    .o_sample_strobe (w_strobe),
    .o_bit_end       (w_bit_end),
    .o_bit_cnt       (w_bit_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_prev_rx && !w_rx) begin
          w_next  = START;
          w_start = 1'b1;
        end
      end
      START: begin
        if (w_strobe && w_bit) w_next = IDLE;
        else if (w_bit_end)    w_next = DATA;
      end
      DATA: begin
        if (w_bit_end && (w_bit_cnt == c_BIT_W'(DATA_WIDTH)))
          w_next = r_par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (w_bit_end) w_next = STOP;
      end
      // Leave at the stop decision point so a following start edge is not missed.
      STOP: begin
        if (w_strobe) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_rx    <= 1'b1;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_par_bad    <= 1'b0;
      r_shift      <= '0;
      r_pdata      <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_prev_rx    <= w_rx;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      if (w_start) begin
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
        r_par_bad <= 1'b0;
      end
      if ((r_state == DATA) && w_strobe)
        r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
      if ((r_state == PARITY) && w_strobe)
        r_par_bad <= (w_bit != calc_parity(32'(r_shift), r_par_typ));
      if (w_done) begin
        r_par_err <= r_par_bad;
        r_stp_err <= ~w_bit;
        if (!r_par_bad && w_bit) begin
          r_data_valid <= 1'b1;
          r_pdata      <= r_shift;
        end
      end
    end
  end

  assign P_DATA     = r_pdata;
  assign Data_Valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed scoreboard bench for uart_rx (DATA_WIDTH=8, PRESCALE=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int DW = 8;
  localparam int PS = 8;
  localparam int M  = PS / 2;
`ifdef RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          rx      = 1'b1;
  logic          par_en  = 1'b0;
  logic          par_typ = 1'b0;
  logic [DW-1:0] p_data;
  logic          dv;
  logic          pe;
  logic          se;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (rx),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .P_DATA     (p_data),
    .Data_Valid (dv),
    .par_err    (pe),
    .stp_err    (se)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] data;
    int            when;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            checks    = 0;
  int            errors    = 0;
  logic [DW-1:0] last_good = '0;

  // A pulse seen at a negedge is consumed at the next posedge, numbered cyc+1.
  always @(negedge clk) begin
    if (dv || pe || se) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL spurious_pulse: observed dv=%b pe=%b se=%b at cycle %0d, expected none", dv, pe, se, cyc + 1);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        assert ({dv, pe, se} === {e.dv, e.pe, e.se}) else begin
          errors++;
          $error("FAIL pulse_flags: observed dv/pe/se=%b%b%b expected %b%b%b", dv, pe, se, e.dv, e.pe, e.se);
        end
        checks++;
        assert (p_data === e.data) else begin
          errors++;
          $error("FAIL p_data: observed 0x%0h expected 0x%0h", p_data, e.data);
        end
        checks++;
        assert ((cyc + 1) == e.when) else begin
          errors++;
          $error("FAIL pulse_cycle: observed %0d expected %0d", cyc + 1, e.when);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (PS) @(posedge clk);
    #1;
  endtask

  // Drives one frame; par_en/par_typ are flipped after the start edge to prove they are latched.
  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                            input logic bad_par, input logic stopbit);
    exp_t x;
    logic ep;
    int   det;
    ep     = ptyp ? ~(^d) : (^d);
    det    = cyc + 1;
    x.pe   = pen & bad_par;
    x.se   = ~stopbit;
    x.dv   = ~x.pe & ~x.se;
    if (x.dv) last_good = d;
    x.data = last_good;
    x.when = det + (DW + 1 + (pen ? 1 : 0)) * PS + M + 2 + SYNC_LAT;
    sb.push_back(x);
    par_en  = pen;
    par_typ = ptyp;
    send_bit(1'b0);
    par_en  = ~pen;
    par_typ = ~ptyp;
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (pen) send_bit(ep ^ bad_par);
    send_bit(stopbit);
  endtask

  task automatic drain(input int n, input string tag);
    repeat (n) @(posedge clk);
    #1;
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s: pending pulses observed %0d expected 0", tag, sb.size());
    end
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    assert ({dv, pe, se, p_data} === {3'b000, {DW{1'b0}}}) else begin
      errors++;
      $error("FAIL %s: observed dv/pe/se=%b%b%b p_data=0x%0h expected all 0", tag, dv, pe, se, p_data);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_state");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Basic frame, no parity: pulse at detection + 78.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(12, "a5_done");

    // Even parity good, then bad parity (P_DATA must hold 0x3C), then odd parity good.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    drain(12, "par_good");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    drain(12, "par_bad");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
    drain(12, "par_odd");

    // Two-cycle start glitch must be ignored, then a normal frame.
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    drain(20, "glitch");
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(12, "after_glitch");

    // Stop bit sampled 0.
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    drain(12, "stop_err");

    // Break: line low for 200 cycles yields exactly one stp_err.
    begin
      exp_t x;
      x.dv = 1'b0; x.pe = 1'b0; x.se = 1'b1; x.data = last_good;
      x.when = cyc + 1 + (DW + 1) * PS + M + 2 + SYNC_LAT;
      sb.push_back(x);
      par_en = 1'b0;
      rx = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      rx = 1'b1;
    end
    drain(20, "break");

    // Back-to-back frames: second start edge 80 cycles after the first.
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(12, "back_to_back");

    // Reset 40 cycles into a frame discards it and clears the outputs.
    d = 8'hC3;
    par_en = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("mid_frame_reset");
    rst = 1'b0;
    last_good = '0;
    drain(100, "after_reset");
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(12, "c3_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
